jam_cost_server: RTL and testbench

Cost-table responder for the job-assignment (JAM) search engine. Holds the 8×8 worker/job cost matrix and answers the engine's W/J lookups with Cost on the following falling edge. Counts completed permutation sweeps and captures the engine's final MatchCount/MinCost when Valid fires. Sits between the stimulus/loader and the JAM core, and serves as the bench-side cost model.

---
 rtl/jam_cost_if.sv | 32 +++
 rtl/jam_cost_server.sv | 132 +++++++++++++
 tb/tb_jam_cost_server.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/jam_cost_if.sv
// Bus bundle between the cost server and its two neighbours: the table
// loader (ld_*) and the JAM search core (W/J/Cost lookups plus the result
// strobe). The server takes the slave modport; the loader/core side takes master.
interface jam_cost_if #(
    parameter int COST_W = 7
) ();
    logic              ld_valid;
    logic [COST_W-1:0] ld_data;
    logic              ld_ready;
    logic              table_full;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [3:0]        MatchCount;
    logic [9:0]        MinCost;
    logic [15:0]       perm_count;
    logic [3:0]        res_match;
    logic [9:0]        res_min;
    logic              done;
    logic              err;

    modport slave (
        input  ld_valid, ld_data, W, J, Valid, MatchCount, MinCost,
        output ld_ready, table_full, Cost, perm_count, res_match, res_min, done, err
    );

    modport master (
        output ld_valid, ld_data, W, J, Valid, MatchCount, MinCost,
        input  ld_ready, table_full, Cost, perm_count, res_match, res_min, done, err
    );
endinterface

// File: rtl/jam_cost_server.sv
// Cost-table responder for the JAM search engine. The table is loaded
// row-major (worker-major) in LOAD. In SERVE it answers {W,J} lookups on
// the falling edge, so the core can sample Cost on its next rising edge.
// It also counts completed worker sweeps and captures the core's final result.
module jam_cost_server #(
    parameter int COST_W = 7,
    parameter int N      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    jam_cost_if.slave  bus
);
    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [AW-1:0]     wr_ptr;
    logic [2:0]        prev_w;
    logic [COST_W-1:0] table_mem [DEPTH];
    logic [AW-1:0]     rd_addr;

    logic              accept;
    logic              capture;
    logic              sweep_end;
    logic              proto_err;

    logic [COST_W-1:0] cost_q;
    logic [15:0]       perm_q;
    logic [3:0]        match_q;
    logic [9:0]        min_q;
    logic              done_q;
    logic              err_q;

    assign rd_addr = {bus.W, bus.J};

    // State register; DONE is only left through reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_LOAD;
        else     state <= state_nx;
    end

    // Next-state decode plus the per-state strobes that drive the datapath.
    always_comb begin
        state_nx       = state;
        bus.ld_ready   = 1'b0;
        bus.table_full = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
        sweep_end      = 1'b0;
        proto_err      = 1'b0;
        case (state)
            ST_LOAD: begin
                bus.ld_ready = 1'b1;
                accept       = bus.ld_valid;
                proto_err    = bus.Valid;
                if (bus.ld_valid && (wr_ptr == AW'(DEPTH - 1))) state_nx = ST_SERVE;
            end
            ST_SERVE: begin
                bus.table_full = 1'b1;
                proto_err      = bus.ld_valid;
                sweep_end      = (prev_w == 3'd6) && (bus.W == 3'd7);
                if (bus.Valid) begin
                    capture  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.table_full = 1'b1;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    // Write pointer for the load phase; wraps to 0 after the last word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         wr_ptr <= '0;
        else if (accept) wr_ptr <= wr_ptr + 1'b1;
    end

    // Cost storage is deliberately not reset; it is fully rewritten after every reset.
    always_ff @(posedge CLK) begin
        if (accept) table_mem[wr_ptr] <= bus.ld_data;
    end

    // Previous worker index, used to spot the 6->7 step that closes a sweep.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) prev_w <= 3'd0;
        else     prev_w <= bus.W;
    end

    // Saturating sweep counter; only advances in SERVE, so it freezes in DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                 perm_q <= 16'd0;
        else if (sweep_end && perm_q != 16'hFFFF) perm_q <= perm_q + 16'd1;
    end

    // Result capture on the first Valid seen in SERVE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            match_q <= 4'd0;
            min_q   <= 10'd0;
            done_q  <= 1'b0;
        end else if (capture) begin
            match_q <= bus.MatchCount;
            min_q   <= bus.MinCost;
            done_q  <= 1'b1;
        end
    end

    // Sticky protocol-error flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            err_q <= 1'b0;
        else if (proto_err) err_q <= 1'b1;
    end

    // Falling-edge lookup register gives the core a half-cycle, registered Cost.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST)                  cost_q <= '0;
        else if (state == ST_LOAD) cost_q <= '0;
        else                      cost_q <= table_mem[rd_addr];
    end

    assign bus.Cost       = cost_q;
    assign bus.perm_count = perm_q;
    assign bus.res_match  = match_q;
    assign bus.res_min    = min_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server. A behavioural model tracks the
// phase, the loaded table, the sweep count and the captured result. Every
// DUT output is compared against that model or against fixed expected values.
module tb_jam_cost_server;
    logic CLK = 1'b0;
    logic RST;

    jam_cost_if #(.COST_W(7)) bus ();

    jam_cost_server #(.COST_W(7), .N(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time-unit period, rising edges at 5, 15, 25 ...
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 = loading, 1 = serving, 2 = result held.
    int m_phase;
    int m_wr;
    int m_prev_w;
    int m_perm;
    int m_match;
    int m_min;
    int m_done;
    int m_err;
    int m_tab [64];

    task automatic model_reset();
        m_phase  = 0;
        m_wr     = 0;
        m_prev_w = 0;
        m_perm   = 0;
        m_match  = 0;
        m_min    = 0;
        m_done   = 0;
        m_err    = 0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, let one rising edge pass, and update the model
    // with what the server should have seen at that edge.
    task automatic apply_stimulus(input logic lv, input logic [6:0] ld,
                                  input logic [2:0] w, input logic [2:0] j,
                                  input logic vld, input logic [3:0] mc, input logic [9:0] mn);
        bus.ld_valid   = lv;
        bus.ld_data    = ld;
        bus.W          = w;
        bus.J          = j;
        bus.Valid      = vld;
        bus.MatchCount = mc;
        bus.MinCost    = mn;
        @(posedge CLK);
        case (m_phase)
            0: begin
                if (vld) m_err = 1;
                if (lv) begin
                    m_tab[m_wr] = int'(ld);
                    m_wr++;
                    if (m_wr == 64) m_phase = 1;
                end
            end
            1: begin
                if (lv) m_err = 1;
                if (m_prev_w == 6 && int'(w) == 7 && m_perm < 65535) m_perm++;
                if (vld) begin
                    m_match = int'(mc);
                    m_min   = int'(mn);
                    m_done  = 1;
                    m_phase = 2;
                end
            end
            default: ;
        endcase
        m_prev_w = int'(w);
        #1;
    endtask

    task automatic lookup(input int w, input int j);
        apply_stimulus(1'b0, 7'd0, 3'(w), 3'(j), 1'b0, 4'd0, 10'd0);
        check_output("cost", 32'(bus.Cost), (m_phase == 0) ? 32'd0 : 32'(m_tab[w * 8 + j]));
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".ld_ready"},   32'(bus.ld_ready),   (m_phase == 0) ? 32'd1 : 32'd0);
        check_output({tag, ".table_full"}, 32'(bus.table_full), (m_phase == 0) ? 32'd0 : 32'd1);
        check_output({tag, ".perm_count"}, 32'(bus.perm_count), 32'(m_perm));
        check_output({tag, ".res_match"},  32'(bus.res_match),  32'(m_match));
        check_output({tag, ".res_min"},    32'(bus.res_min),    32'(m_min));
        check_output({tag, ".done"},       32'(bus.done),       32'(m_done));
        check_output({tag, ".err"},        32'(bus.err),        32'(m_err));
    endtask

    initial begin
        int first_word;
        int base_perm;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = 7'd0;
        bus.W          = 3'd0;
        bus.J          = 3'd0;
        bus.Valid      = 1'b0;
        bus.MatchCount = 4'd0;
        bus.MinCost    = 10'd0;
        RST            = 1'b1;
        model_reset();

        // Reset values, taken asynchronously before any clock edge
        #2;
        check_all("reset");
        check_output("reset.cost", 32'(bus.Cost), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Valid during LOAD flags an error and captures nothing
        apply_stimulus(1'b0, 7'd0, 3'd0, 3'd0, 1'b1, 4'd5, 10'd100);
        check_all("valid_in_load");
        check_output("valid_in_load.err_const", 32'(bus.err), 32'd1);

        // Partial load followed by an asynchronous mid-cycle reset
        for (int i = 0; i < 20; i++)
            apply_stimulus(1'b1, 7'($urandom_range(127)), 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
        check_all("partial_load");
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all("mid_load_reset");
        check_output("mid_load_reset.err_const", 32'(bus.err), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Contiguous load of k mod 100; ready must drop after exactly 64 words
        for (int k = 0; k < 64; k++) begin
            apply_stimulus(1'b1, 7'(k % 100), 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
            check_output("load.ld_ready", 32'(bus.ld_ready), (k != 63) ? 32'd1 : 32'd0);
            if (k == 62) begin
                check_output("load.not_full_at_63", 32'(bus.table_full), 32'd0);
                check_output("load.cost_held", 32'(bus.Cost), 32'd0);
            end
        end
        check_output("load.table_full", 32'(bus.table_full), 32'd1);
        check_all("after_load");

        // Directed lookups, then random ones
        lookup(3, 5);
        check_output("cost_3_5", 32'(bus.Cost), 32'd29);
        lookup(7, 7);
        check_output("cost_7_7", 32'(bus.Cost), 32'd63);
        for (int i = 0; i < 16; i++)
            lookup(int'($urandom_range(7)), int'($urandom_range(7)));
        check_all("random_lookups");

        // Load strobe in SERVE sets err and leaves the table untouched
        apply_stimulus(1'b1, 7'h55, 3'd3, 3'd5, 1'b0, 4'd0, 10'd0);
        lookup(3, 5);
        check_output("serve_ld.cost_3_5", 32'(bus.Cost), 32'd29);
        check_all("serve_ld");

        // Three full sweeps, then a sweep that stops at worker 6
        base_perm = m_perm;
        lookup(0, 0);
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 8; w++)
                lookup(w, int'($urandom_range(7)));
        check_all("sweeps");
        check_output("sweeps.delta", 32'(bus.perm_count), 32'(base_perm + 3));
        for (int w = 0; w < 7; w++)
            lookup(w, int'($urandom_range(7)));
        lookup(0, 1);
        check_output("short_sweep.delta", 32'(bus.perm_count), 32'(base_perm + 3));

        // Result capture on the same edge as a sweep completion
        lookup(6, 3);
        apply_stimulus(1'b0, 7'd0, 3'd7, 3'd2, 1'b1, 4'd4, 10'd338);
        check_all("capture");
        check_output("capture.res_match", 32'(bus.res_match), 32'd4);
        check_output("capture.res_min", 32'(bus.res_min), 32'd338);
        check_output("capture.perm", 32'(bus.perm_count), 32'(base_perm + 4));

        // A later Valid is ignored without error; Cost keeps tracking, count frozen
        apply_stimulus(1'b0, 7'd0, 3'd1, 3'd1, 1'b1, 4'd9, 10'd777);
        check_all("second_valid");
        for (int w = 0; w < 8; w++)
            lookup(w, int'($urandom_range(7)));
        lookup(7, 7);
        check_all("done_sweep");

        // Reset out of DONE clears Cost immediately, then a gapped load
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all("reset_from_done");
        check_output("reset_from_done.cost", 32'(bus.Cost), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        first_word = -1;
        for (int c = 0; c < 128; c++) begin
            logic [6:0] d;
            d = 7'($urandom_range(127));
            if (c == 1) first_word = int'(d);
            apply_stimulus(1'(c % 2), d, 3'd0, 3'd0, 1'b0, 4'd0, 10'd0);
            check_output("gapped.ld_ready", 32'(bus.ld_ready), (c < 127) ? 32'd1 : 32'd0);
        end
        check_output("gapped.table_full", 32'(bus.table_full), 32'd1);
        lookup(0, 0);
        check_output("gapped.first_word", 32'(bus.Cost), 32'(first_word));
        check_all("gapped");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
